// File: rtl/sample_bank_seq.sv
// Capture bank for the FFT 32:1 select mux: fills 32 samples over valid/ready,
// then drains by sweeping the mux select in natural or bit-reversed order.
module sample_bank_seq #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic                   bitrev_en,
  output logic [(2**AW)*DW-1:0]  bank,
  output logic [AW-1:0]          sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
);

  localparam int unsigned DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]   rd_nxt;
  logic [AW-1:0]   sel_q, sel_d;
  logic            bitrev_q, bitrev_d;
  logic            frame_done_q, frame_done_d;
  logic            wr_en;
  logic [DW-1:0]   bank_q [DEPTH];

  // Mirror the index bits so the drain can emit FFT bit-reversed order.
  function automatic logic [AW-1:0] reverse_idx(input logic [AW-1:0] idx);
    logic [AW-1:0] r;
    r = '0;
    for (int b = 0; b < int'(AW); b++) begin
      r[b] = idx[int'(AW) - 1 - b];
    end
    return r;
  endfunction

  // Next-state, counter and bank-write decode.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    sel_d        = sel_q;
    bitrev_d     = bitrev_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    rd_nxt       = rd_cnt_q + 1'b1;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            sel_d    = '0;
            bitrev_d = bitrev_en;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d     = '0;
            sel_d        = '0;
            frame_done_d = 1'b1;
            state_d      = FILL;
          end else begin
            rd_cnt_d = rd_nxt;
            sel_d    = bitrev_q ? reverse_idx(rd_nxt) : rd_nxt;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, select, drain-order latch and frame-done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      sel_q        <= '0;
      bitrev_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      sel_q        <= sel_d;
      bitrev_q     <= bitrev_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sample bank; written only on FILL accepts, frozen during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_en) begin
      bank_q[wr_cnt_q] <= in_data;
    end
  end

  // Flatten the bank onto the mux inputs x0..x31.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
    assign bank[g*DW +: DW] = bank_q[g];
  end

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sample_bank_seq.sv
// Directed bench for sample_bank_seq: natural/bit-reversed drains, backpressure,
// sparse fill and reset in the middle of a drain.
module tb_sample_bank_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned N  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            bitrev_en;
  logic [N*DW-1:0] bank;
  logic [AW-1:0]   sel;
  logic            out_valid;
  logic            out_ready;
  logic            frame_done;

  int checks = 0;
  int errors = 0;

  sample_bank_seq #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .bitrev_en  (bitrev_en),
    .bank       (bank),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rev5(input logic [AW-1:0] i);
    logic [AW-1:0] r;
    r = {i[0], i[1], i[2], i[3], i[4]};
    return r;
  endfunction

  function automatic logic [DW-1:0] entry(input logic [AW-1:0] idx);
    return bank[DW*int'(idx) +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push 32 samples base+k; sparse inserts an idle cycle before each accept.
  task automatic fill(input logic [DW-1:0] base, input logic br, input logic sparse);
    for (int k = 0; k < int'(N); k++) begin
      if (sparse) begin
        in_valid = 1'b0;
        tick();
        check("sparse_no_drain", 32'(out_valid), 32'd0);
      end
      check("fill_ready", 32'(in_ready), 32'd1);
      check("fill_no_valid", 32'(out_valid), 32'd0);
      in_valid  = 1'b1;
      in_data   = DW'(base + DW'(k));
      bitrev_en = br;
      tick();
    end
    in_valid  = 1'b0;
    bitrev_en = ~br;
    check("drain_entry_valid", 32'(out_valid), 32'd1);
    check("drain_entry_ready", 32'(in_ready), 32'd0);
    check("drain_entry_sel", 32'(sel), 32'd0);
  endtask

  // Drain nhs entries; bp applies out_ready pattern 1,0,0,1; DEAD offered on input.
  task automatic drain(input logic [DW-1:0] base, input logic br, input logic bp, input int nhs);
    int hs;
    int cyc;
    logic [AW-1:0] exp;
    hs  = 0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    while (hs < nhs) begin
      exp = br ? rev5(AW'(hs)) : AW'(hs);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_sel", 32'(sel), 32'(exp));
      check("drain_bank", 32'(entry(sel)), 32'(DW'(base + DW'(exp))));
      check("drain_no_done", 32'(frame_done), 32'd0);
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (out_ready) hs++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (nhs == int'(N)) begin
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_ready", 32'(in_ready), 32'd1);
      check("done_no_valid", 32'(out_valid), 32'd0);
      check("done_sel", 32'(sel), 32'd0);
      tick();
      check("done_one_cycle", 32'(frame_done), 32'd0);
      check("bank_kept0", 32'(entry(5'd0)), 32'(base));
      check("bank_kept31", 32'(entry(5'd31)), 32'(DW'(base + 16'd31)));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bitrev_en = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    #4 rst_n = 1'b1;
    tick();
    check("rst_bank", 32'(|bank), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    fill(16'h1000, 1'b0, 1'b0);
    drain(16'h1000, 1'b0, 1'b0, 32);

    fill(16'h1000, 1'b1, 1'b0);
    drain(16'h1000, 1'b1, 1'b0, 32);

    fill(16'h2000, 1'b0, 1'b0);
    drain(16'h2000, 1'b0, 1'b1, 32);

    fill(16'h3000, 1'b1, 1'b1);
    drain(16'h3000, 1'b1, 1'b1, 32);

    fill(16'h4000, 1'b0, 1'b0);
    drain(16'h4000, 1'b0, 1'b0, 10);
    check("mid_drain_sel", 32'(sel), 32'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_bank", 32'(|bank), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_no_valid", 32'(out_valid), 32'd0);
    fill(16'h5000, 1'b0, 1'b0);
    drain(16'h5000, 1'b0, 1'b0, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
